// File: rtl/kmi_cmd_sequencer.sv
// kmi_cmd_sequencer: sends one PS/2 host command to the KMI over APB, retries on RESEND or bad
// replies, then collects the device's response bytes. Define KMI_SEQ_STATS_EN for err_count.
module kmi_cmd_sequencer #(
    parameter int         MAX_RETRY      = 3,
    parameter int         TIMEOUT_CYCLES = 65536,
    parameter logic [7:0] ACK_BYTE       = 8'hFA,
    parameter logic [7:0] RESEND_BYTE    = 8'hFE
) (
    input  logic       pclk,
    input  logic       nkmirst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_byte,
    input  logic [1:0] cmd_nresp,
    output logic       resp_valid,
    output logic [7:0] resp_byte,
    output logic       done,
    output logic [1:0] err,
    output logic       psel,
    output logic       penable,
    output logic       pwrite,
    output logic [7:0] pwdata,
    input  logic [7:0] prdata,
    input  logic       pready,
    input  logic       kmiintr,
    output logic [7:0] err_count
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_RETRY   = 2'd2;

    typedef enum logic [3:0] {
        IDLE,
        TX_SETUP,
        TX_ACCESS,
        WAIT_ACK,
        RD_SETUP,
        RD_ACCESS,
        CHECK,
        WAIT_RESP,
        EMIT,
        DONE
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [7:0]      cmd_q;
    logic [1:0]      remain_q;
    logic [RW-1:0]   retry_q;
    logic [TW-1:0]   timer_q;
    logic [7:0]      rdata_q;
    logic [1:0]      err_q;
    logic            ret_emit_q;

    logic            accept;
    logic            timer_clr;
    logic            timer_inc;
    logic            ret_load;
    logic            ret_emit_d;
    logic            cap_rdata;
    logic            retry_inc;
    logic            remain_dec;
    logic            err_load;
    logic [1:0]      err_val;
    logic            retry_req;

    // A RESEND and any unrecognised reply are both answered by re-sending the command.
    assign retry_req = (rdata_q == RESEND_BYTE) || (rdata_q != ACK_BYTE);

    always_ff @(posedge pclk or negedge nkmirst) begin
        if (!nkmirst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        timer_clr  = 1'b0;
        timer_inc  = 1'b0;
        ret_load   = 1'b0;
        ret_emit_d = 1'b0;
        cap_rdata  = 1'b0;
        retry_inc  = 1'b0;
        remain_dec = 1'b0;
        err_load   = 1'b0;
        err_val    = ERR_OK;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    accept  = 1'b1;
                    state_d = TX_SETUP;
                end
            end
            TX_SETUP: state_d = TX_ACCESS;
            TX_ACCESS: begin
                if (pready) begin
                    timer_clr = 1'b1;
                    state_d   = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (kmiintr) begin
                    ret_load   = 1'b1;
                    ret_emit_d = 1'b0;
                    state_d    = RD_SETUP;
                end else if (timer_q == TIMER_LAST) begin
                    err_load = 1'b1;
                    err_val  = ERR_TIMEOUT;
                    state_d  = DONE;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            RD_SETUP: state_d = RD_ACCESS;
            RD_ACCESS: begin
                if (pready) begin
                    cap_rdata = 1'b1;
                    state_d   = ret_emit_q ? EMIT : CHECK;
                end
            end
            CHECK: begin
                if (retry_req) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_inc = 1'b1;
                        state_d   = TX_SETUP;
                    end else begin
                        err_load = 1'b1;
                        err_val  = ERR_RETRY;
                        state_d  = DONE;
                    end
                end else if (remain_q == 2'd0) begin
                    err_load = 1'b1;
                    state_d  = DONE;
                end else begin
                    timer_clr = 1'b1;
                    state_d   = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (kmiintr) begin
                    ret_load   = 1'b1;
                    ret_emit_d = 1'b1;
                    state_d    = RD_SETUP;
                end else if (timer_q == TIMER_LAST) begin
                    err_load = 1'b1;
                    err_val  = ERR_TIMEOUT;
                    state_d  = DONE;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            EMIT: begin
                remain_dec = 1'b1;
                if (remain_q == 2'd1) begin
                    err_load = 1'b1;
                    state_d  = DONE;
                end else begin
                    timer_clr = 1'b1;
                    state_d   = WAIT_RESP;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge nkmirst) begin
        if (!nkmirst) begin
            cmd_q      <= 8'h00;
            remain_q   <= 2'd0;
            retry_q    <= '0;
            timer_q    <= '0;
            rdata_q    <= 8'h00;
            err_q      <= ERR_OK;
            ret_emit_q <= 1'b0;
        end else begin
            if (accept) begin
                cmd_q    <= cmd_byte;
                remain_q <= cmd_nresp;
                retry_q  <= '0;
                err_q    <= ERR_OK;
            end
            if (retry_inc) begin
                retry_q <= retry_q + 1'b1;
            end
            if (remain_dec) begin
                remain_q <= remain_q - 2'd1;
            end
            if (timer_clr) begin
                timer_q <= '0;
            end else if (timer_inc) begin
                timer_q <= timer_q + 1'b1;
            end
            if (ret_load) begin
                ret_emit_q <= ret_emit_d;
            end
            if (cap_rdata) begin
                rdata_q <= prdata;
            end
            if (err_load) begin
                err_q <= err_val;
            end
        end
    end

`ifdef KMI_SEQ_STATS_EN
    logic [7:0] err_count_q;

    always_ff @(posedge pclk or negedge nkmirst) begin
        if (!nkmirst) begin
            err_count_q <= 8'h00;
        end else if (err_load && (err_val != ERR_OK) && (err_count_q != 8'hFF)) begin
            err_count_q <= err_count_q + 8'd1;
        end
    end

    assign err_count = err_count_q;
`else
    assign err_count = 8'h00;
`endif

    // cmd handshake: a command is taken on any rising edge where cmd_valid && cmd_ready;
    // cmd_ready is high only in IDLE, so it stays low from acceptance through the done cycle.
    assign cmd_ready  = (state_q == IDLE);
    assign psel       = (state_q == TX_SETUP) || (state_q == TX_ACCESS) ||
                        (state_q == RD_SETUP) || (state_q == RD_ACCESS);
    assign penable    = (state_q == TX_ACCESS) || (state_q == RD_ACCESS);
    assign pwrite     = (state_q == TX_SETUP) || (state_q == TX_ACCESS);
    assign pwdata     = cmd_q;
    assign resp_valid = (state_q == EMIT);
    assign resp_byte  = rdata_q;
    assign done       = (state_q == DONE);
    assign err        = err_q;

endmodule

// File: tb/tb_kmi_cmd_sequencer.sv
// tb_kmi_cmd_sequencer: drives commands into the sequencer while a scripted KMI device answers
// over APB; a transaction-level model predicts writes, response bytes and completion status.
`timescale 1ns/1ps
module tb_kmi_cmd_sequencer;

  localparam int TMO = 100;
  localparam int MAX_RETRY = 3;
  localparam logic [7:0] ACK = 8'hFA;
  localparam logic [7:0] RESEND = 8'hFE;

  logic pclk = 1'b0;
  logic nkmirst = 1'b0;
  logic cmd_valid = 1'b0;
  logic [7:0] cmd_byte = 8'h00;
  logic [1:0] cmd_nresp = 2'd0;
  logic [7:0] prdata = 8'h00;
  logic pready = 1'b0;
  logic kmiintr = 1'b0;
  logic cmd_ready, resp_valid, done, psel, penable, pwrite;
  logic [7:0] resp_byte, pwdata, err_count;
  logic [1:0] err;

  kmi_cmd_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
    .pclk(pclk), .nkmirst(nkmirst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_byte(cmd_byte), .cmd_nresp(cmd_nresp), .resp_valid(resp_valid), .resp_byte(resp_byte),
    .done(done), .err(err), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .kmiintr(kmiintr), .err_count(err_count)
  );

  // clock / reset block
  always #5 pclk = ~pclk;

  int checks = 0;
  int passes = 0;

  logic [7:0] script_q[$];
  logic [7:0] dev_q[$];
  logic [7:0] exp_q[$];
  int exp_err, exp_writes, exp_resp_total, exp_err_count;
  logic [7:0] cur_cmd;
  bit busy, load_req, done_seen, resp_phase;
  int cyc, last_rdy_cyc, done_cyc;
  bit last_rdy_write;
  int n_writes, n_reads, n_access, n_resp, got_err;
  logic [7:0] last_resp;
  int force_stall = -1;
  int stall_left = 0;
  int intr_cnt = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: walk the reply script the way the command protocol consumes it.
  task automatic build_expect(input logic [1:0] nresp_in);
    int idx;
    int retries;
    bit fin;
    idx = 0;
    retries = 0;
    fin = 0;
    exp_q.delete();
    exp_writes = 0;
    exp_err = 0;
    while (!fin) begin
      exp_writes++;
      if (idx >= script_q.size()) begin
        exp_err = 1;
        fin = 1;
      end else if (script_q[idx] == ACK) begin
        idx++;
        for (int i = 0; i < int'(nresp_in); i++) begin
          if (idx >= script_q.size()) begin
            exp_err = 1;
            break;
          end
          exp_q.push_back(script_q[idx]);
          idx++;
        end
        fin = 1;
      end else begin
        idx++;
        if (retries < MAX_RETRY) retries++;
        else begin
          exp_err = 2;
          fin = 1;
        end
      end
    end
    exp_resp_total = exp_q.size();
  endtask

  task automatic schedule_intr();
    int d;
    if (dev_q.size() > 0) begin
      d = $urandom_range(0, 20);
      if (d == 0) kmiintr = 1'b1;
      else intr_cnt = d;
    end
  endtask

  // KMI device: answers APB transfers with random stalls, raises kmiintr while it has replies.
  initial begin
    forever begin
      @(posedge pclk); #1;
      if (load_req) begin
        dev_q = script_q;
        kmiintr = 1'b0;
        intr_cnt = -1;
        resp_phase = 0;
        load_req = 0;
      end
      if (!nkmirst) begin
        pready = 1'b0;
        continue;
      end
      if (intr_cnt > 0) begin
        intr_cnt--;
        if (intr_cnt == 0) begin
          kmiintr = 1'b1;
          intr_cnt = -1;
        end
      end
      if (psel && penable) begin
        if (stall_left > 0) begin
          pready = 1'b0;
          stall_left--;
        end else begin
          pready = 1'b1;
          last_rdy_cyc = cyc;
          last_rdy_write = pwrite;
          if (pwrite) begin
            resp_phase = 0;
            schedule_intr();
          end else begin
            kmiintr = 1'b0;
            if (dev_q.size() > 0) prdata = dev_q.pop_front();
            else prdata = 8'($urandom_range(0, 255));
            if (resp_phase || prdata == ACK) begin
              resp_phase = 1;
              schedule_intr();
            end
          end
        end
      end else begin
        pready = 1'b0;
        if (psel) stall_left = (force_stall >= 0) ? force_stall : $urandom_range(0, 5);
      end
    end
  end

  // scoreboard: compare DUT outputs to the model every cycle
  initial begin
    forever begin
      @(negedge pclk);
      cyc++;
      if (!nkmirst) begin
        busy = 0;
        exp_q.delete();
        exp_err_count = 0;
        continue;
      end
      chk("cmd_ready", cmd_ready, !busy);
      chk("psel_while_idle", psel & cmd_ready, 0);
      chk("penable_without_psel", penable & ~psel, 0);
      if (psel && penable) n_access++;
      if (psel && !penable) begin
        if (pwrite) begin
          n_writes++;
          chk("pwdata", pwdata, cur_cmd);
        end else begin
          n_reads++;
        end
      end
      if (resp_valid) begin
        n_resp++;
        last_resp = resp_byte;
        if (exp_q.size() > 0) chk("resp_byte", resp_byte, exp_q.pop_front());
      end
      if (done) begin
        chk("done_err", err, exp_err);
        chk("apb_writes", n_writes, exp_writes);
        chk("resp_count", n_resp, exp_resp_total);
        if (exp_err == 1) chk("timeout_gap", cyc - last_rdy_cyc, last_rdy_write ? 102 : 103);
`ifdef KMI_SEQ_STATS_EN
        if (exp_err != 0 && exp_err_count < 255) exp_err_count++;
`endif
        chk("err_count", err_count, exp_err_count);
        got_err = err;
        done_cyc = cyc;
        busy = 0;
        done_seen = 1;
      end
      if (cmd_valid && cmd_ready) begin
        busy = 1;
        n_writes = 0;
        n_reads = 0;
        n_access = 0;
        n_resp = 0;
      end
    end
  end

  // driver tasks
  task automatic issue(input logic [7:0] c, input logic [1:0] nr);
    int budget;
    build_expect(nr);
    cur_cmd = c;
    load_req = 1;
    budget = 0;
    while ((load_req || !cmd_ready) && budget < 200) begin
      @(posedge pclk); #1;
      budget++;
    end
    if (budget >= 200) chk("accept_wait", cmd_ready, 1);
    done_seen = 0;
    cmd_valid = 1'b1;
    cmd_byte = c;
    cmd_nresp = nr;
    @(posedge pclk); #1;
    cmd_valid = 1'b0;
    cmd_byte = 8'($urandom_range(0, 255));
    cmd_nresp = 2'($urandom_range(0, 3));
  endtask

  task automatic run_cmd(input logic [7:0] c, input logic [1:0] nr);
    int budget;
    issue(c, nr);
    budget = 0;
    while (!done_seen && budget < 3000) begin
      @(posedge pclk); #1;
      budget++;
    end
    if (!done_seen) chk("done_wait", done_seen, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", passes, checks + 1);
    $fatal(1);
  end

  initial begin
    int nr, nbad, errs_so_far;
    logic [7:0] b;
    repeat (3) @(posedge pclk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_pwdata", pwdata, 8'h00);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_byte", resp_byte, 8'h00);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_err_count", err_count, 8'h00);
    nkmirst = 1'b1;
    @(posedge pclk); #1;

    script_q.delete(); script_q.push_back(8'hFA);
    run_cmd(8'hF4, 2'd0);
    chk("f4_writes", n_writes, 1);
    chk("f4_reads", n_reads, 1);
    chk("f4_err", got_err, 0);
    chk("f4_resp", n_resp, 0);

    script_q.delete(); script_q.push_back(8'hFA); script_q.push_back(8'hAA);
    run_cmd(8'hFF, 2'd1);
    chk("ff_resp", n_resp, 1);
    chk("ff_byte", last_resp, 8'hAA);
    chk("ff_err", got_err, 0);

    script_q.delete();
    script_q.push_back(8'hFE); script_q.push_back(8'hFE); script_q.push_back(8'hFA);
    run_cmd(8'hED, 2'd0);
    chk("ed_writes", n_writes, 3);
    chk("ed_err", got_err, 0);

    script_q.delete();
    for (int i = 0; i < 6; i++) script_q.push_back(8'hFE);
    run_cmd(8'hF0, 2'd0);
    chk("resend_writes", n_writes, 4);
    chk("resend_err", got_err, 2);
`ifdef KMI_SEQ_STATS_EN
    chk("resend_err_count", err_count, 8'd1);
`else
    chk("resend_err_count", err_count, 8'd0);
`endif

    force_stall = 5;
    script_q.delete();
    run_cmd(8'hF2, 2'd0);
    chk("tmo_err", got_err, 1);
    chk("tmo_writes", n_writes, 1);
    chk("tmo_access_cycles", n_access, 6);
    chk("tmo_gap", done_cyc - last_rdy_cyc, 102);
    force_stall = -1;

    script_q.delete();
    script_q.push_back(8'hFA); script_q.push_back(8'hFA); script_q.push_back(8'h12);
    run_cmd(8'hE9, 2'd2);
    chk("ackdata_resp", n_resp, 2);
    chk("ackdata_last", last_resp, 8'h12);

    // reset in the middle of an APB write access
    force_stall = 40;
    script_q.delete(); script_q.push_back(8'hFA);
    issue(8'hF5, 2'd0);
    begin
      int budget;
      budget = 0;
      while (!(psel && penable) && budget < 50) begin
        @(posedge pclk); #1;
        budget++;
      end
      if (budget >= 50) chk("reach_access", penable, 1);
    end
    repeat (2) @(posedge pclk);
    #3;
    nkmirst = 1'b0;
    #1;
    chk("arst_psel", psel, 0);
    chk("arst_penable", penable, 0);
    chk("arst_cmd_ready", cmd_ready, 1);
    chk("arst_done", done, 0);
    chk("arst_err_count", err_count, 8'h00);
    @(posedge pclk); #1;
    nkmirst = 1'b1;
    force_stall = -1;
    @(posedge pclk); #1;

    script_q.delete(); script_q.push_back(8'hFA); script_q.push_back(8'h55);
    run_cmd(8'hF3, 2'd1);
    chk("post_rst_err", got_err, 0);
    chk("post_rst_byte", last_resp, 8'h55);

    // randomized commands against the model
    errs_so_far = 0;
    for (int n = 0; n < 40; n++) begin
      nr = $urandom_range(0, 3);
      script_q.delete();
      nbad = $urandom_range(0, 5);
      for (int i = 0; i < nbad; i++) begin
        b = $urandom_range(0, 1) ? RESEND : 8'($urandom_range(0, 255));
        if (b == ACK) b = RESEND;
        script_q.push_back(b);
      end
      script_q.push_back(ACK);
      for (int i = 0; i < nr; i++) begin
        b = ($urandom_range(0, 3) == 0) ? ACK : 8'($urandom_range(0, 255));
        script_q.push_back(b);
      end
      if ($urandom_range(0, 7) == 0) void'(script_q.pop_back());
      run_cmd(8'($urandom_range(0, 255)), 2'(nr));
      if (got_err != 0) errs_so_far++;
    end

    repeat (3) @(posedge pclk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
